// File: rtl/kitchen_timer_pkg.sv
// Shared types and constants for the kitchen timer countdown engine.
// Colours are packed {R[2:0], G[2:0], B[1:0]} to match the display stage's controls.
package kitchen_timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_e;

    localparam logic [7:0] WHITE = {3'd7, 3'd7, 2'd3};
    localparam logic [7:0] GREEN = {3'd0, 3'd7, 2'd0};
    localparam logic [7:0] RED   = {3'd7, 3'd0, 2'd0};
    localparam logic [7:0] BLACK = {3'd0, 3'd0, 2'd0};

    // Single BCD digit step with wrap at an arbitrary top value (9 or 5).
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d,
                                                 input logic [BCD_W-1:0] top);
        return (d == top) ? '0 : d + 1'b1;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] d,
                                                 input logic [BCD_W-1:0] top);
        return (d == '0) ? top : d - 1'b1;
    endfunction

endpackage

// File: rtl/kitchen_timer_core_bcd_mmss_counter.sv
// MM:SS BCD register file: increments minutes or seconds independently,
// decrements the whole time by one second with borrow, or clears.
module bcd_mmss_counter
    import kitchen_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_min,
    input  logic             inc_sec,
    input  logic             dec,
    input  logic             clear,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_units,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_units,
    output logic             is_zero
);

    localparam logic [BCD_W-1:0] D9 = BCD_W'(9);
    localparam logic [BCD_W-1:0] D5 = BCD_W'(5);

    logic [BCD_W-1:0] mt_q, mu_q, st_q, su_q;
    logic [BCD_W-1:0] mt_d, mu_d, st_d, su_d;

    assign is_zero = (mt_q == '0) && (mu_q == '0) && (st_q == '0) && (su_q == '0);

    always_comb begin
        mt_d = mt_q;
        mu_d = mu_q;
        st_d = st_q;
        su_d = su_q;
        if (clear) begin
            mt_d = '0;
            mu_d = '0;
            st_d = '0;
            su_d = '0;
        end else if (dec && !is_zero) begin
            su_d = bcd_dec(su_q, D9);
            if (su_q == '0) begin
                st_d = bcd_dec(st_q, D5);
                if (st_q == '0) begin
                    mu_d = bcd_dec(mu_q, D9);
                    if (mu_q == '0) begin
                        mt_d = bcd_dec(mt_q, D9);
                    end
                end
            end
        end else if (inc_min) begin
            mu_d = bcd_inc(mu_q, D9);
            if (mu_q == D9) begin
                mt_d = bcd_inc(mt_q, D9);
            end
        end else if (inc_sec) begin
            // Seconds wrap 59 -> 00 without carrying into minutes.
            su_d = bcd_inc(su_q, D9);
            if (su_q == D9) begin
                st_d = bcd_inc(st_q, D5);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mt_q <= '0;
            mu_q <= '0;
            st_q <= '0;
            su_q <= '0;
        end else begin
            mt_q <= mt_d;
            mu_q <= mu_d;
            st_q <= st_d;
            su_q <= su_d;
        end
    end

    assign min_tens  = mt_q;
    assign min_units = mu_q;
    assign sec_tens  = st_q;
    assign sec_units = su_q;

endmodule

// File: rtl/kitchen_timer_core.sv
// Kitchen timer countdown engine: button edge detect, IDLE/RUN/PAUSE/ALARM FSM,
// one-second prescaler, alarm blink/timeout, and registered display colour.
module kitchen_timer_core
    import kitchen_timer_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int BLINK_DIV  = 25000000,
    parameter int ALARM_SECS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_min,
    input  logic             btn_sec,
    input  logic             btn_start,
    input  logic             btn_clr,
    output logic [BCD_W-1:0] num1,
    output logic [BCD_W-1:0] num2,
    output logic [BCD_W-1:0] num3,
    output logic [BCD_W-1:0] num4,
    output logic [2:0]       R_control,
    output logic [2:0]       G_control,
    output logic [1:0]       B_control,
    output logic             running,
    output logic             alarm
);

    localparam int ALARM_CYC = ALARM_SECS * TICK_DIV;
    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int AW = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYC - 1);

    // Button order in the history vector: {clr, start, min, sec}
    logic [3:0]    btn_q, btn_d, pulse;
    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [7:0]    colour_q, colour_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;

    logic clr_p, start_p, min_p, sec_p;
    logic inc_min, inc_sec, dec, clear;
    logic is_zero, is_one;
    logic [BCD_W-1:0] mt, mu, st, su;

    bcd_mmss_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_min  (inc_min),
        .inc_sec  (inc_sec),
        .dec      (dec),
        .clear    (clear),
        .min_tens (mt),
        .min_units(mu),
        .sec_tens (st),
        .sec_units(su),
        .is_zero  (is_zero)
    );

    assign is_one = (mt == '0) && (mu == '0) && (st == '0) && (su == BCD_W'(1));

    always_comb begin
        btn_d   = {btn_clr, btn_start, btn_min, btn_sec};
        pulse   = btn_d & ~btn_q;
        // Only the highest-priority pulse acts: clr > start > min > sec.
        clr_p   = pulse[3];
        start_p = pulse[2] & ~pulse[3];
        min_p   = pulse[1] & ~pulse[3] & ~pulse[2];
        sec_p   = pulse[0] & ~pulse[3] & ~pulse[2] & ~pulse[1];
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        blink_d = blink_q;
        phase_d = phase_q;
        acnt_d  = acnt_q;
        inc_min = 1'b0;
        inc_sec = 1'b0;
        dec     = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_p) begin
                    clear = 1'b1;
                end else if (start_p) begin
                    if (!is_zero) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end else if (min_p) begin
                    inc_min = 1'b1;
                end else if (sec_p) begin
                    inc_sec = 1'b1;
                end
            end
            RUN: begin
                if (clr_p) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                    pre_d   = '0;
                end else if (start_p) begin
                    state_d = PAUSE;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    dec   = 1'b1;
                    if (is_one) begin
                        state_d = ALARM;
                        blink_d = '0;
                        phase_d = 1'b0;
                        acnt_d  = '0;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            PAUSE: begin
                if (clr_p) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                    pre_d   = '0;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                if (clr_p || start_p || (acnt_q == ALARM_LAST)) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                    blink_d = '0;
                    phase_d = 1'b0;
                    acnt_d  = '0;
                end else begin
                    acnt_d = acnt_q + 1'b1;
                    if (blink_q == BLINK_LAST) begin
                        blink_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-state so they line up with the state register.
    always_comb begin
        running_d = (state_d == RUN);
        alarm_d   = (state_d == ALARM);
        case (state_d)
            RUN:     colour_d = GREEN;
            ALARM:   colour_d = phase_d ? BLACK : RED;
            default: colour_d = WHITE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q     <= '0;
            state_q   <= IDLE;
            pre_q     <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            acnt_q    <= '0;
            colour_q  <= WHITE;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            btn_q     <= btn_d;
            state_q   <= state_d;
            pre_q     <= pre_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            acnt_q    <= acnt_d;
            colour_q  <= colour_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign num1      = mt;
    assign num2      = mu;
    assign num3      = st;
    assign num4      = su;
    assign R_control = colour_q[7:5];
    assign G_control = colour_q[4:2];
    assign B_control = colour_q[1:0];
    assign running   = running_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_kitchen_timer_core.sv
// Scoreboard bench for kitchen_timer_core: a seconds-based reference model pushes
// the expected outputs every cycle; a monitor pops and compares them.
module tb_kitchen_timer_core;

    localparam int TD = 4;
    localparam int BD = 2;
    localparam int AS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_min = 1'b0, btn_sec = 1'b0, btn_start = 1'b0, btn_clr = 1'b0;
    logic [3:0] num1, num2, num3, num4;
    logic [2:0] R_control, G_control;
    logic [1:0] B_control;
    logic running, alarm;

    kitchen_timer_core #(.TICK_DIV(TD), .BLINK_DIV(BD), .ALARM_SECS(AS)) dut (
        .clk(clk), .rst(rst),
        .btn_min(btn_min), .btn_sec(btn_sec), .btn_start(btn_start), .btn_clr(btn_clr),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .R_control(R_control), .G_control(G_control), .B_control(B_control),
        .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic [7:0]  colour;
        logic        run;
        logic        alm;
    } obs_t;

    obs_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: whole minutes/seconds as integers, elapsed alarm cycles.
    int m_state = M_IDLE;
    int m_min = 0, m_sec = 0, m_pre = 0, m_el = 0;
    logic [3:0] m_prev = '0;

    function automatic obs_t model_obs();
        obs_t o;
        o.digits = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
        o.run    = (m_state == M_RUN);
        o.alm    = (m_state == M_ALARM);
        if (m_state == M_RUN)        o.colour = 8'b000_111_00;
        else if (m_state == M_ALARM) o.colour = (((m_el / BD) % 2) == 1) ? 8'h00 : 8'b111_000_00;
        else                         o.colour = 8'hFF;
        return o;
    endfunction

    task automatic model_step();
        logic [3:0] b, p;
        logic clr, start, mn, sc;
        int t;
        b = {btn_clr, btn_start, btn_min, btn_sec};
        if (rst) begin
            m_state = M_IDLE; m_min = 0; m_sec = 0; m_pre = 0; m_el = 0; m_prev = '0;
        end else begin
            p = b & ~m_prev;
            m_prev = b;
            clr   = p[3];
            start = p[2] && !clr;
            mn    = p[1] && !p[3] && !p[2];
            sc    = p[0] && !p[3] && !p[2] && !p[1];
            case (m_state)
                M_IDLE: begin
                    if (clr) begin m_min = 0; m_sec = 0; end
                    else if (start) begin
                        if (m_min + m_sec > 0) begin m_state = M_RUN; m_pre = 0; end
                    end
                    else if (mn) m_min = (m_min + 1) % 100;
                    else if (sc) m_sec = (m_sec + 1) % 60;
                end
                M_RUN: begin
                    if (clr) begin m_state = M_IDLE; m_min = 0; m_sec = 0; m_pre = 0; end
                    else if (start) m_state = M_PAUSE;
                    else if (m_pre == TD - 1) begin
                        m_pre = 0;
                        t = m_min * 60 + m_sec - 1;
                        m_min = t / 60;
                        m_sec = t % 60;
                        if (t == 0) begin m_state = M_ALARM; m_el = 0; end
                    end else m_pre++;
                end
                M_PAUSE: begin
                    if (clr) begin m_state = M_IDLE; m_min = 0; m_sec = 0; end
                    else if (start) m_state = M_RUN;
                end
                default: begin
                    if (clr || start || (m_el == AS * TD - 1)) m_state = M_IDLE;
                    else m_el++;
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        sb.push_back(model_obs());
    end

    initial forever begin
        obs_t e, a;
        @(posedge clk);
        #1;
        a = '{digits: {num1, num2, num3, num4}, colour: {R_control, G_control, B_control},
              run: running, alm: alarm};
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got digits=%h col=%h run=%b alm=%b expected digits=%h col=%h run=%b alm=%b",
                         $time, a.digits, a.colour, a.run, a.alm, e.digits, e.colour, e.run, e.alm);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic press(input int which);
        @(negedge clk);
        case (which)
            0: btn_sec = 1'b1;
            1: btn_min = 1'b1;
            2: btn_start = 1'b1;
            default: btn_clr = 1'b1;
        endcase
        @(negedge clk);
        btn_sec = 1'b0; btn_min = 1'b0; btn_start = 1'b0; btn_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] digs();
        return {num1, num2, num3, num4};
    endfunction

    function automatic logic [15:0] col();
        return {8'h00, R_control, G_control, B_control};
    endfunction

    initial begin
        // 1: reset
        do_reset();
        @(negedge clk);
        chk("reset_digits", digs(), 16'h0000);
        chk("reset_colour", col(), 16'h00FF);
        chk("reset_flags", {14'd0, running, alarm}, 16'h0000);

        // 2: loading and minute wrap; start at 00:00 ignored
        press(2);
        chk("start_at_zero", {15'd0, running}, 16'h0000);
        repeat (3) press(1);
        repeat (62) press(0);
        chk("load_0302", digs(), 16'h0302);
        repeat (97) press(1);
        chk("min_wrap", digs(), 16'h0002);

        // 3: run with borrows
        do_reset();
        press(1);
        press(2);
        chk("run_flag", {15'd0, running}, 16'h0001);
        chk("run_colour", col(), 16'h001C);
        repeat (4) @(negedge clk);
        chk("borrow_0059", digs(), 16'h0059);
        repeat (40) @(negedge clk);
        chk("borrow_0049", digs(), 16'h0049);

        // 4: alarm entry, blink and timeout
        do_reset();
        repeat (2) press(0);
        press(2);
        repeat (8) @(negedge clk);
        chk("alarm_entry", {15'd0, alarm}, 16'h0001);
        chk("alarm_digits", digs(), 16'h0000);
        chk("alarm_red", col(), 16'h00E0);
        @(negedge clk);
        chk("alarm_red2", col(), 16'h00E0);
        @(negedge clk);
        chk("alarm_dark", col(), 16'h0000);
        repeat (10) @(negedge clk);
        chk("alarm_timeout", {14'd0, running, alarm}, 16'h0000);
        chk("alarm_exit_colour", col(), 16'h00FF);

        // 5: pause keeps prescaler position
        do_reset();
        repeat (5) press(0);
        press(2);
        @(negedge clk);
        press(2);
        chk("paused", {15'd0, running}, 16'h0000);
        repeat (20) @(negedge clk);
        chk("pause_hold", digs(), 16'h0005);
        press(2);
        @(negedge clk);
        chk("resume_no_tick", digs(), 16'h0005);
        @(negedge clk);
        chk("resume_tick", digs(), 16'h0004);

        // 6: clr beats start; reset mid-run
        do_reset();
        repeat (5) press(0);
        press(2);
        @(negedge clk);
        btn_clr = 1'b1; btn_start = 1'b1;
        @(negedge clk);
        btn_clr = 1'b0; btn_start = 1'b0;
        chk("clr_prio", {digs()[15:1], running}, 16'h0000);
        repeat (3) press(0);
        press(2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_run", {digs()[15:2], running, alarm}, 16'h0000);
        chk("rst_mid_colour", col(), 16'h00FF);

        // Randomized traffic, scoreboard only
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 399) == 0);
            btn_clr   = ($urandom_range(0, 79) == 0);
            btn_start = ($urandom_range(0, 19) == 0);
            btn_min   = (i < 2000) ? ($urandom_range(0, 11) == 0) : 1'b0;
            btn_sec   = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        rst = 1'b0; btn_clr = 1'b0; btn_start = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
